// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: funct codes, default
// widths, FSM state encoding and the decoded control bundle.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_SHAMT_W = 5;

    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_MULTU = 6'd25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [5:0] signal;
        logic       binvert;
        logic       cin;
        logic       uses_alu;
        logic       is_mul;
        logic       is_shift;
        logic       illegal;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, response and slice-ALU drive signals of the sequencer.
// master = sequencer side, slave = decode stage / ALU / consumer side.
interface alu_op_sequencer_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_funct;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [5:0]       alu_signal;
    logic             alu_binvert;
    logic             alu_cin;
    logic             alu_reset;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [WIDTH-1:0] rsp_hi;
    logic [WIDTH-1:0] rsp_lo;
    logic             rsp_err;

    modport master (
        input  req_valid, req_funct, req_a, req_b,
        input  alu_result, alu_cout, rsp_ready,
        output req_ready,
        output alu_signal, alu_binvert, alu_cin, alu_reset, alu_a, alu_b,
        output rsp_valid, rsp_result, rsp_hi, rsp_lo, rsp_err
    );

    modport slave (
        output req_valid, req_funct, req_a, req_b,
        output alu_result, alu_cout, rsp_ready,
        input  req_ready,
        input  alu_signal, alu_binvert, alu_cin, alu_reset, alu_a, alu_b,
        input  rsp_valid, rsp_result, rsp_hi, rsp_lo, rsp_err
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational funct decoder: produces the slice-ALU control word and the
// operation class used by the sequencer FSM.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [5:0] funct,
    output alu_ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (funct)
            FN_AND, FN_OR, FN_ADD: begin
                ctrl.signal   = funct;
                ctrl.uses_alu = 1'b1;
            end
            // Subtract-type ops run a + ~b + 1 through the slice adders.
            FN_SUB, FN_SLT: begin
                ctrl.signal   = funct;
                ctrl.binvert  = 1'b1;
                ctrl.cin      = 1'b1;
                ctrl.uses_alu = 1'b1;
            end
            FN_MULTU: begin
                ctrl.signal = FN_ADD;
                ctrl.is_mul = 1'b1;
            end
            FN_SRL: begin
                ctrl.is_shift = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues single-pass ops to the slice ALU, sequences MULTU as WIDTH shift-add
// passes through the ALU adder, and executes SRL locally.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_op_sequencer_if.master bus
);

    seq_state_t       state_reg, state_next;
    logic [5:0]       funct_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic [WIDTH-1:0] rsp_hi_reg;
    logic [WIDTH-1:0] rsp_lo_reg;
    logic             rsp_err_reg;

    logic [5:0]       dec_funct;
    alu_ctrl_t        ctrl;
    logic             accept;
    logic             mul_last;
    logic [WIDTH-1:0] shift_result;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    // In IDLE the incoming funct is decoded to pick the next state; afterwards
    // the latched funct drives the ALU controls.
    assign dec_funct = (state_reg == ST_IDLE) ? bus.req_funct : funct_reg;

    alu_ctrl_decode u_decode (
        .funct (dec_funct),
        .ctrl  (ctrl)
    );

    assign accept       = (state_reg == ST_IDLE) && bus.req_valid;
    assign mul_last     = (cnt_reg == SHAMT_W'(WIDTH - 1));
    assign shift_result = bus.req_a >> bus.req_b[SHAMT_W-1:0];
    // {hi,lo} shifted right by one with the adder carry entering at the top.
    assign mul_hi_next  = {bus.alu_cout, bus.alu_result[WIDTH-1:1]};
    assign mul_lo_next  = {bus.alu_result[0], op_b_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (ctrl.is_mul)        state_next = ST_MUL;
                    else if (ctrl.uses_alu) state_next = ST_EXEC;
                    else                    state_next = ST_RESP;
                end
            end
            ST_EXEC: state_next = ST_RESP;
            ST_MUL:  if (mul_last) state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.alu_reset   = 1'b1;
        bus.alu_signal  = '0;
        bus.alu_binvert = 1'b0;
        bus.alu_cin     = 1'b0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        case (state_reg)
            ST_IDLE: bus.req_ready = 1'b1;
            ST_EXEC: begin
                bus.alu_reset   = 1'b0;
                bus.alu_signal  = ctrl.signal;
                bus.alu_binvert = ctrl.binvert;
                bus.alu_cin     = ctrl.cin;
                bus.alu_a       = op_a_reg;
                bus.alu_b       = op_b_reg;
            end
            ST_MUL: begin
                bus.alu_reset  = 1'b0;
                bus.alu_signal = FN_ADD;
                bus.alu_a      = hi_reg;
                bus.alu_b      = op_b_reg[0] ? op_a_reg : '0;
            end
            ST_RESP: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // op_a_reg doubles as the multiplicand and op_b_reg as the LO shift
    // register while a MULTU is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            funct_reg      <= '0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            hi_reg         <= '0;
            cnt_reg        <= '0;
            rsp_result_reg <= '0;
            rsp_hi_reg     <= '0;
            rsp_lo_reg     <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        funct_reg <= bus.req_funct;
                        op_a_reg  <= bus.req_a;
                        op_b_reg  <= bus.req_b;
                        hi_reg    <= '0;
                        cnt_reg   <= '0;
                        if (ctrl.is_shift) begin
                            rsp_result_reg <= shift_result;
                            rsp_err_reg    <= 1'b0;
                        end else if (ctrl.illegal) begin
                            rsp_result_reg <= '0;
                            rsp_err_reg    <= 1'b1;
                        end
                    end
                end
                ST_EXEC: rsp_result_reg <= bus.alu_result;
                ST_MUL: begin
                    hi_reg   <= mul_hi_next;
                    op_b_reg <= mul_lo_next;
                    cnt_reg  <= cnt_reg + SHAMT_W'(1);
                    if (mul_last) begin
                        rsp_hi_reg     <= mul_hi_next;
                        rsp_lo_reg     <= mul_lo_next;
                        rsp_result_reg <= mul_lo_next;
                    end
                end
                ST_RESP: if (bus.rsp_ready) rsp_err_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_hi     = rsp_hi_reg;
    assign bus.rsp_lo     = rsp_lo_reg;
    assign bus.rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural slice-ALU model and a
// queue-based scoreboard checked by an independent response monitor.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(W)) bus ();

    alu_op_sequencer #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural model of the combinational slice ALU.
    logic [W:0]   alu_sum;
    logic [W-1:0] alu_b_eff;
    always_comb begin
        alu_b_eff      = bus.alu_binvert ? ~bus.alu_b : bus.alu_b;
        alu_sum        = {1'b0, bus.alu_a} + {1'b0, alu_b_eff} + {{W{1'b0}}, bus.alu_cin};
        bus.alu_cout   = bus.alu_reset ? 1'b0 : alu_sum[W];
        bus.alu_result = '0;
        if (!bus.alu_reset) begin
            case (bus.alu_signal)
                FN_AND:         bus.alu_result = bus.alu_a & bus.alu_b;
                FN_OR:          bus.alu_result = bus.alu_a | bus.alu_b;
                FN_ADD, FN_SUB: bus.alu_result = alu_sum[W-1:0];
                FN_SLT:         bus.alu_result = {{(W-1){1'b0}}, ($signed(bus.alu_a) < $signed(bus.alu_b))};
                default:        bus.alu_result = '0;
            endcase
        end
    end

    typedef struct {
        logic [W-1:0] result;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         err;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake pops and compares one expectation.
    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got result 0x%08h, required no response", bus.rsp_result);
            end else begin
                mon_e = sb.pop_front();
                $display("rsp %-10s result=0x%08h hi=0x%08h lo=0x%08h err=%0b",
                         mon_e.name, bus.rsp_result, bus.rsp_hi, bus.rsp_lo, bus.rsp_err);
                check({mon_e.name, "_result"}, bus.rsp_result, mon_e.result);
                check({mon_e.name, "_hi"}, bus.rsp_hi, mon_e.hi);
                check({mon_e.name, "_lo"}, bus.rsp_lo, mon_e.lo);
                check({mon_e.name, "_err"}, {{(W-1){1'b0}}, bus.rsp_err}, {{(W-1){1'b0}}, mon_e.err});
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
    task automatic issue(input string name, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input logic ee);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got req_ready=0, required 1", name);
        end
        e.result = er; e.hi = eh; e.lo = el; e.err = ee; e.name = name;
        sb.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_funct = f;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Latency counted in edges from (and including) the accept edge.
    task automatic wait_valid(input string name, input int exp_lat);
        int lat;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_funct = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("reset_alu_reset", {31'd0, bus.alu_reset}, 32'd1);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // ADD with signed-overflow operands: controls visible in EXEC.
        issue("ADD", FN_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
        check("ADD_exec_signal", {26'd0, bus.alu_signal}, 32'd32);
        check("ADD_exec_binv_cin", {30'd0, bus.alu_binvert, bus.alu_cin}, 32'd0);
        check("ADD_exec_alu_reset", {31'd0, bus.alu_reset}, 32'd0);
        check("ADD_busy", {31'd0, bus.req_ready}, 32'd0);
        wait_valid("ADD", 2);

        issue("SUB", FN_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0);
        check("SUB_exec_binv_cin", {30'd0, bus.alu_binvert, bus.alu_cin}, 32'd3);
        check("SUB_exec_signal", {26'd0, bus.alu_signal}, 32'd34);
        wait_valid("SUB", 2);

        issue("AND", FN_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 32'h0, 32'h0, 1'b0);
        wait_valid("AND", 2);
        issue("OR", FN_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 32'h0, 32'h0, 1'b0);
        wait_valid("OR", 2);

        // Full-scale MULTU: 33 busy cycles with rsp_ready held high.
        issue("MULTU_FF", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        check("MULTU_exec_signal", {26'd0, bus.alu_signal}, 32'd32);
        wait_valid("MULTU_FF", 33);
        @(posedge clk); #1;
        check("MULTU_FF_ready_after", {31'd0, bus.req_ready}, 32'd1);

        // HI/LO persist through non-multiply ops.
        issue("SLT", FN_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        check("SLT_exec_binv_cin", {30'd0, bus.alu_binvert, bus.alu_cin}, 32'd3);
        wait_valid("SLT", 2);

        issue("SRL31", FN_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        check("SRL31_alu_reset", {31'd0, bus.alu_reset}, 32'd1);
        wait_valid("SRL31", 1);

        issue("MULTU_3x5", FN_MULTU, 32'd3, 32'd5, 32'd15, 32'd0, 32'd15, 1'b0);
        wait_valid("MULTU_3x5", 33);

        // Only the low shift-amount bits count: 0x24 shifts by 4.
        issue("SRL_amt", FN_SRL, 32'h1234_5678, 32'h0000_0024, 32'h0123_4567, 32'd0, 32'd15, 1'b0);
        wait_valid("SRL_amt", 1);

        // Illegal funct with back-pressure: response must stay put.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        issue("ILLEGAL", 6'h3F, 32'hDEAD_BEEF, 32'h1, 32'h0, 32'd0, 32'd15, 1'b1);
        check("ILLEGAL_valid", {31'd0, bus.rsp_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("ILLEGAL_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("ILLEGAL_hold_err", {31'd0, bus.rsp_err}, 32'd1);
            check("ILLEGAL_hold_result", bus.rsp_result, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("ILLEGAL_cleared_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("ILLEGAL_cleared_err", {31'd0, bus.rsp_err}, 32'd0);

        // Asynchronous reset in the middle of a multiply.
        issue("MULTU_rst", FN_MULTU, 32'h0000_1234, 32'h0000_5678, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid_err", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        check("rst_alu_ctrl", {24'd0, bus.alu_signal, bus.alu_binvert, bus.alu_cin}, 32'd0);
        check("rst_alu_reset", {31'd0, bus.alu_reset}, 32'd1);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_rsp_hi", bus.rsp_hi, 32'd0);
        check("rst_rsp_lo", bus.rsp_lo, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        issue("ADD_2p2", FN_ADD, 32'd2, 32'd2, 32'd4, 32'd0, 32'd0, 1'b0);
        wait_valid("ADD_2p2", 2);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
